// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads words over a req/ack memory port and
// presents them to execute over valid/ready, loading the PC from next_pc on each consume.
module instr_fetch #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic [ADDR_W-1:0]  next_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   retired,
    output logic               busy,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_next;

    // Handshakes: a memory read completes in a cycle where mem_req && mem_ack;
    // an instruction transfers to execute in a cycle where instr_valid && instr_ready.
    logic fetch_done;
    logic consume;

    assign fetch_done  = (state == REQ) && mem_ack;
    assign consume     = (state == HOLD) && instr_ready;

    assign mem_req     = (state == REQ);
    assign mem_addr    = pc;
    assign instr_valid = (state == HOLD);
    assign busy        = (state != IDLE);
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            state <= state_next;
            if (fetch_done) begin
                instr <= mem_data;
            end
            if (consume) begin
                pc      <= next_pc;
                retired <= retired + 1'b1;
            end
        end
    end

    // run is only looked at in IDLE and at the consume, so dropping it mid-request
    // still lets the outstanding word reach execute.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run) state_next = REQ;
            end
            REQ: begin
                if (mem_ack) state_next = HOLD;
            end
            HOLD: begin
                if (instr_ready) state_next = run ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a memory model answers requests, expected words
// go into a scoreboard queue when acked and are compared when presented to execute.
module tb_instr_fetch;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   retired;
    logic               busy;
    logic [1:0]         fsm_state;

    instr_fetch #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .RESET_PC('0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .next_pc    (next_pc),
        .pc         (pc),
        .retired    (retired),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [INSTR_W-1:0] mem [256];
    logic [INSTR_W-1:0] exp_q [$];
    logic [ADDR_W-1:0]  m_pc;
    logic [CNT_W-1:0]   m_retired;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expects the DUT to be in its request phase at entry; completes one fetch and consume.
    task automatic fetch_one(input int ack_delay, input int hold_cycles, input logic [ADDR_W-1:0] nxt);
        logic [INSTR_W-1:0] exp_w;
        check("req_high", mem_req, 1'b1);
        check("req_addr", mem_addr, m_pc);
        check("req_busy", busy, 1'b1);
        for (int i = 0; i < ack_delay; i++) begin
            mem_ack     = 1'b0;
            instr_ready = 1'($urandom_range(0, 1));
            next_pc     = 8'($urandom_range(0, 255));
            tick();
            check("wait_req", mem_req, 1'b1);
            check("wait_addr", mem_addr, m_pc);
            check("wait_valid", instr_valid, 1'b0);
            check("wait_retired", retired, m_retired);
        end
        instr_ready = 1'b0;
        mem_ack     = 1'b1;
        mem_data    = mem[m_pc];
        exp_q.push_back(mem[m_pc]);
        tick();
        mem_ack  = 1'b0;
        mem_data = 16'($urandom);
        check("pres_valid", instr_valid, 1'b1);
        check("pres_req_low", mem_req, 1'b0);
        check("pres_pc", pc, m_pc);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp_w = exp_q.pop_front();
            check("pres_instr", instr, exp_w);
        end
        for (int i = 0; i < hold_cycles; i++) begin
            mem_ack  = 1'($urandom_range(0, 1));
            mem_data = 16'($urandom);
            next_pc  = 8'($urandom_range(0, 255));
            tick();
            check("hold_valid", instr_valid, 1'b1);
            check("hold_instr", instr, mem[m_pc]);
            check("hold_pc", pc, m_pc);
            check("hold_no_req", mem_req, 1'b0);
            check("hold_retired", retired, m_retired);
        end
        mem_ack     = 1'b0;
        instr_ready = 1'b1;
        next_pc     = nxt;
        tick();
        instr_ready = 1'b0;
        next_pc     = 8'($urandom_range(0, 255));
        m_pc        = nxt;
        m_retired   = m_retired + 1'b1;
        check("cons_pc", pc, m_pc);
        check("cons_retired", retired, m_retired);
        check("cons_valid", instr_valid, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        mem[0] = 16'h1234;
        reset = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_data = '0;
        instr_ready = 1'b0; next_pc = '0;
        m_pc = '0; m_retired = '0;
        tick(); tick();
        check("rst_req", mem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_pc", pc, 8'h00);
        check("rst_instr", instr, 16'h0000);
        check("rst_retired", retired, 8'h00);
        check("rst_busy", busy, 1'b0);

        reset = 1'b0;
        tick();
        check("idle_stay", busy, 1'b0);

        // first fetch, stall, then sequential and branch targets including 0xFF -> 0x00
        run = 1'b1;
        tick();
        fetch_one(1, 5, 8'h01);
        fetch_one(0, 0, 8'h2A);
        fetch_one(2, 1, 8'hFF);
        fetch_one(0, 0, 8'h00);
        fetch_one(0, 0, 8'h05);

        // run dropped during the request: word still delivered, then idle
        run = 1'b0;
        fetch_one(3, 0, 8'h10);
        check("stop_busy", busy, 1'b0);
        check("stop_req", mem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1; instr_ready = 1'b1; next_pc = 8'h77;
            tick();
            check("idle_pc", pc, m_pc);
            check("idle_retired", retired, m_retired);
            check("idle_instr", instr, mem[8'h05]);
            check("idle_busy", busy, 1'b0);
            check("idle_valid", instr_valid, 1'b0);
        end
        mem_ack = 1'b0; instr_ready = 1'b0;
        run = 1'b1;
        tick();
        fetch_one(0, 0, 8'h11);

        // reset while requesting, with a late ack right after
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0; mem_ack = 1'b1; mem_data = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        m_pc = '0; m_retired = '0;
        check("mrst_valid", instr_valid, 1'b0);
        check("mrst_pc", pc, 8'h00);
        check("mrst_req", mem_req, 1'b0);
        check("mrst_instr", instr, 16'h0000);
        check("mrst_retired", retired, 8'h00);
        check("mrst_busy", busy, 1'b0);

        // random traffic
        run = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 2), 8'($urandom_range(0, 255)));
        end

        // drive the counter to its maximum, then one more consume wraps it
        while (m_retired != 8'hFF) begin
            fetch_one(0, 0, m_pc + 8'h01);
        end
        check("cnt_max", retired, 8'hFF);
        fetch_one(0, 0, m_pc + 8'h01);
        check("cnt_wrap", retired, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
